// File: rtl/soft_reset_ctrl.sv
// Soft-reset and watchdog controller: a keyed register write or a watchdog expiry
// issues a fixed-width reg_soft_reset pulse followed by a trigger-dropping hold-off.
module soft_reset_ctrl #(
  parameter int unsigned PULSE_CYCLES   = 16,
  parameter int unsigned HOLDOFF_CYCLES = 64,
  parameter logic [31:0] KEY            = 32'h5AA5_C33C,
  parameter int unsigned WDT_WIDTH      = 24
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic                 reg_wr_en,
  input  logic [31:0]          reg_wr_data,
  input  logic                 wdt_en,
  input  logic [WDT_WIDTH-1:0] wdt_timeout,
  input  logic                 wdt_kick,
  output logic                 reg_soft_reset,
  output logic                 busy,
  output logic [7:0]           reset_cnt,
  output logic [1:0]           last_cause
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ASSERT  = 2'b01,
    HOLDOFF = 2'b10
  } state_t;

  localparam logic [15:0]          PULSE_LAST = 16'(PULSE_CYCLES - 1);
  localparam logic [15:0]          HOLD_LAST  = 16'(HOLDOFF_CYCLES - 1);
  localparam logic [WDT_WIDTH-1:0] WDT_ZERO   = {WDT_WIDTH{1'b0}};
  localparam logic [WDT_WIDTH-1:0] WDT_ONE    = WDT_WIDTH'(1);

  state_t               state_r;
  logic [15:0]          phase_r;
  logic [WDT_WIDTH-1:0] wdt_cnt_r;
  logic                 sw_trig_s;
  logic                 wdt_trig_s;
  logic                 wdt_load_s;

  // Trigger qualification; a kick masks a same-cycle expiry.
  always_comb begin
    sw_trig_s  = (state_r == IDLE) && reg_wr_en && (reg_wr_data == KEY);
    wdt_trig_s = (state_r == IDLE) && wdt_en && (wdt_timeout != WDT_ZERO) &&
                 (wdt_cnt_r == WDT_ZERO) && !wdt_kick;
    wdt_load_s = !wdt_en || wdt_kick || (state_r != IDLE);
  end

  // Watchdog down-counter, reloaded whenever it is not actively counting in IDLE.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      wdt_cnt_r <= wdt_timeout;
    end else if (wdt_load_s) begin
      wdt_cnt_r <= wdt_timeout;
    end else if (wdt_cnt_r != WDT_ZERO) begin
      wdt_cnt_r <= wdt_cnt_r - WDT_ONE;
    end else begin
      wdt_cnt_r <= wdt_cnt_r;
    end
  end

  // Pulse/hold-off FSM with registered outputs and trigger bookkeeping.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_r        <= IDLE;
      phase_r        <= 16'd0;
      reg_soft_reset <= 1'b0;
      busy           <= 1'b0;
      reset_cnt      <= 8'd0;
      last_cause     <= 2'b00;
    end else begin
      case (state_r)
        IDLE: begin
          if (sw_trig_s || wdt_trig_s) begin
            state_r        <= ASSERT;
            phase_r        <= 16'd0;
            reg_soft_reset <= 1'b1;
            busy           <= 1'b1;
            reset_cnt      <= (reset_cnt == 8'd255) ? 8'd255 : reset_cnt + 8'd1;
            // Software takes priority when both fire in the same cycle.
            last_cause     <= sw_trig_s ? 2'b01 : 2'b10;
          end else begin
            phase_r <= 16'd0;
          end
        end
        ASSERT: begin
          if (phase_r == PULSE_LAST) begin
            state_r        <= HOLDOFF;
            phase_r        <= 16'd0;
            reg_soft_reset <= 1'b0;
          end else begin
            phase_r <= phase_r + 16'd1;
          end
        end
        HOLDOFF: begin
          if (phase_r == HOLD_LAST) begin
            state_r <= IDLE;
            phase_r <= 16'd0;
            busy    <= 1'b0;
          end else begin
            phase_r <= phase_r + 16'd1;
          end
        end
        default: begin
          state_r        <= IDLE;
          phase_r        <= 16'd0;
          reg_soft_reset <= 1'b0;
          busy           <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_soft_reset_ctrl.sv
// Directed bench for soft_reset_ctrl at default parameters (pulse 16, hold-off 64).
module tb_soft_reset_ctrl;

  localparam int          P   = 16;
  localparam int          H   = 64;
  localparam logic [31:0] KEY = 32'h5AA5_C33C;

  logic        sys_clk;
  logic        sys_rst_n;
  logic        reg_wr_en;
  logic [31:0] reg_wr_data;
  logic        wdt_en;
  logic [23:0] wdt_timeout;
  logic        wdt_kick;
  logic        reg_soft_reset;
  logic        busy;
  logic [7:0]  reset_cnt;
  logic [1:0]  last_cause;

  int tests_run;
  int tests_failed;

  soft_reset_ctrl dut (
    .sys_clk        (sys_clk),
    .sys_rst_n      (sys_rst_n),
    .reg_wr_en      (reg_wr_en),
    .reg_wr_data    (reg_wr_data),
    .wdt_en         (wdt_en),
    .wdt_timeout    (wdt_timeout),
    .wdt_kick       (wdt_kick),
    .reg_soft_reset (reg_soft_reset),
    .busy           (busy),
    .reset_cnt      (reset_cnt),
    .last_cause     (last_cause)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic write_key(input logic [31:0] d);
    reg_wr_en   = 1'b1;
    reg_wr_data = d;
    tick();
    reg_wr_en   = 1'b0;
    reg_wr_data = 32'h0;
  endtask

  task automatic do_reset();
    sys_rst_n = 1'b0;
    wdt_en    = 1'b0;
    wdt_kick  = 1'b0;
    reg_wr_en = 1'b0;
    tick();
    tick();
    sys_rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    wdt_timeout = 24'd100;
    sys_rst_n   = 1'b0;
    tick();
    tests_run++; if (reg_soft_reset !== 1'b0) begin tests_failed++; $display("FAIL reset_rsr got %b want 0", reg_soft_reset); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b want 0", busy); end
    tests_run++; if (reset_cnt !== 8'd0) begin tests_failed++; $display("FAIL reset_cnt got %0d want 0", reset_cnt); end
    tests_run++; if (last_cause !== 2'b00) begin tests_failed++; $display("FAIL reset_cause got %b want 00", last_cause); end
    sys_rst_n = 1'b1;
    tick();
  endtask

  task automatic test_key_write();
    do_reset();
    write_key(KEY);
    // After the write edge T, iteration j observes cycle T+1+j.
    for (int j = 0; j < P + H + 2; j++) begin
      tests_run++;
      if (reg_soft_reset !== (j < P)) begin tests_failed++; $display("FAIL key_pulse j=%0d got %b want %b", j, reg_soft_reset, (j < P)); end
      tests_run++;
      if (busy !== (j < P + H)) begin tests_failed++; $display("FAIL key_busy j=%0d got %b want %b", j, busy, (j < P + H)); end
      tick();
    end
    tests_run++; if (reset_cnt !== 8'd1) begin tests_failed++; $display("FAIL key_cnt got %0d want 1", reset_cnt); end
    tests_run++; if (last_cause !== 2'b01) begin tests_failed++; $display("FAIL key_cause got %b want 01", last_cause); end
  endtask

  task automatic test_wrong_key_retrigger();
    do_reset();
    write_key(32'h5AA5_C33D);
    for (int j = 0; j < 5; j++) begin
      tests_run++;
      if (reg_soft_reset !== 1'b0 || busy !== 1'b0) begin tests_failed++; $display("FAIL wrong_key j=%0d rsr=%b busy=%b want 0 0", j, reg_soft_reset, busy); end
      tick();
    end
    tests_run++; if (reset_cnt !== 8'd0) begin tests_failed++; $display("FAIL wrong_key_cnt got %0d want 0", reset_cnt); end
    tests_run++; if (last_cause !== 2'b00) begin tests_failed++; $display("FAIL wrong_key_cause got %b want 00", last_cause); end
    write_key(KEY);
    repeat (39) tick();
    write_key(KEY);
    tests_run++; if (reset_cnt !== 8'd1) begin tests_failed++; $display("FAIL holdoff_drop_cnt got %0d want 1", reset_cnt); end
    tests_run++; if (reg_soft_reset !== 1'b0 || busy !== 1'b1) begin tests_failed++; $display("FAIL holdoff_drop rsr=%b busy=%b want 0 1", reg_soft_reset, busy); end
    repeat (39) tick();
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL busy_last got %b want 1", busy); end
    tick();
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL busy_end got %b want 0", busy); end
    write_key(KEY);
    tests_run++; if (reg_soft_reset !== 1'b1) begin tests_failed++; $display("FAIL retrigger_rsr got %b want 1", reg_soft_reset); end
    tests_run++; if (reset_cnt !== 8'd2) begin tests_failed++; $display("FAIL retrigger_cnt got %0d want 2", reset_cnt); end
    repeat (P + H) tick();
  endtask

  task automatic test_watchdog();
    logic seen;
    wdt_timeout = 24'd100;
    do_reset();
    wdt_en = 1'b1;
    tick();
    for (int j = 1; j <= 100; j++) begin
      tick();
      tests_run++;
      if (reg_soft_reset !== (j == 100)) begin tests_failed++; $display("FAIL wdt_expiry j=%0d got %b want %b", j, reg_soft_reset, (j == 100)); end
    end
    tests_run++; if (last_cause !== 2'b10) begin tests_failed++; $display("FAIL wdt_cause got %b want 10", last_cause); end
    tests_run++; if (reset_cnt !== 8'd1) begin tests_failed++; $display("FAIL wdt_cnt got %0d want 1", reset_cnt); end
    wdt_en = 1'b0;
    repeat (P + H + 2) tick();

    do_reset();
    wdt_en = 1'b1;
    seen   = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      wdt_kick = (i % 50 == 0);
      tick();
      if (reg_soft_reset === 1'b1) seen = 1'b1;
    end
    wdt_kick = 1'b0;
    wdt_en   = 1'b0;
    tests_run++; if (seen !== 1'b0) begin tests_failed++; $display("FAIL wdt_kicked got pulse=%b want 0", seen); end

    wdt_timeout = 24'd0;
    do_reset();
    wdt_en = 1'b1;
    seen   = 1'b0;
    repeat (300) begin
      tick();
      if (reg_soft_reset === 1'b1) seen = 1'b1;
    end
    wdt_en = 1'b0;
    tests_run++; if (seen !== 1'b0) begin tests_failed++; $display("FAIL wdt_disabled got pulse=%b want 0", seen); end
  endtask

  task automatic test_simultaneous();
    logic prev;
    int   rises;
    wdt_timeout = 24'd10;
    do_reset();
    wdt_en = 1'b1;
    tick();
    repeat (9) tick();
    write_key(KEY);
    tests_run++; if (reg_soft_reset !== 1'b1) begin tests_failed++; $display("FAIL both_rsr got %b want 1", reg_soft_reset); end
    tests_run++; if (last_cause !== 2'b01) begin tests_failed++; $display("FAIL both_cause got %b want 01", last_cause); end
    prev  = 1'b1;
    rises = 0;
    for (int j = 1; j <= P + H; j++) begin
      tick();
      if (reg_soft_reset === 1'b1 && prev === 1'b0) rises++;
      prev = reg_soft_reset;
    end
    tests_run++; if (rises !== 0) begin tests_failed++; $display("FAIL both_single extra pulses got %0d want 0", rises); end
    tests_run++; if (reset_cnt !== 8'd1) begin tests_failed++; $display("FAIL both_cnt got %0d want 1", reset_cnt); end
    wdt_en = 1'b0;
    tick();

    do_reset();
    wdt_en = 1'b1;
    tick();
    repeat (9) tick();
    wdt_kick = 1'b1;
    tick();
    wdt_kick = 1'b0;
    tests_run++; if (reg_soft_reset !== 1'b0 || busy !== 1'b0) begin tests_failed++; $display("FAIL kick_expiry rsr=%b busy=%b want 0 0", reg_soft_reset, busy); end
    for (int j = 1; j <= 11; j++) begin
      tick();
      tests_run++;
      if (reg_soft_reset !== (j == 11)) begin tests_failed++; $display("FAIL kick_reload j=%0d got %b want %b", j, reg_soft_reset, (j == 11)); end
    end
    tests_run++; if (last_cause !== 2'b10) begin tests_failed++; $display("FAIL kick_reload_cause got %b want 10", last_cause); end
    wdt_en = 1'b0;
    repeat (P + H + 2) tick();
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 300; i++) begin
      write_key(KEY);
      repeat (P + H) tick();
      if (i == 253) begin
        tests_run++; if (reset_cnt !== 8'd254) begin tests_failed++; $display("FAIL sat_254 got %0d want 254", reset_cnt); end
      end
    end
    tests_run++; if (reset_cnt !== 8'd255) begin tests_failed++; $display("FAIL sat_255 got %0d want 255", reset_cnt); end
    tests_run++; if (last_cause !== 2'b01) begin tests_failed++; $display("FAIL sat_cause got %b want 01", last_cause); end
  endtask

  task automatic test_reset_mid_pulse();
    do_reset();
    write_key(KEY);
    repeat (4) tick();
    tests_run++; if (reg_soft_reset !== 1'b1) begin tests_failed++; $display("FAIL mid_pulse_pre got %b want 1", reg_soft_reset); end
    sys_rst_n = 1'b0;
    tick();
    tests_run++; if (reg_soft_reset !== 1'b0) begin tests_failed++; $display("FAIL mid_rst_rsr got %b want 0", reg_soft_reset); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL mid_rst_busy got %b want 0", busy); end
    tests_run++; if (reset_cnt !== 8'd0) begin tests_failed++; $display("FAIL mid_rst_cnt got %0d want 0", reset_cnt); end
    tests_run++; if (last_cause !== 2'b00) begin tests_failed++; $display("FAIL mid_rst_cause got %b want 00", last_cause); end
    sys_rst_n = 1'b1;
    tick();
    tests_run++; if (reg_soft_reset !== 1'b0 || busy !== 1'b0) begin tests_failed++; $display("FAIL mid_rst_release rsr=%b busy=%b want 0 0", reg_soft_reset, busy); end
    write_key(KEY);
    tests_run++; if (reg_soft_reset !== 1'b1) begin tests_failed++; $display("FAIL mid_rst_idle got %b want 1", reg_soft_reset); end
    tests_run++; if (reset_cnt !== 8'd1) begin tests_failed++; $display("FAIL mid_rst_idle_cnt got %0d want 1", reset_cnt); end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    sys_rst_n    = 1'b0;
    reg_wr_en    = 1'b0;
    reg_wr_data  = 32'h0;
    wdt_en       = 1'b0;
    wdt_timeout  = 24'd100;
    wdt_kick     = 1'b0;
    test_reset();
    test_key_write();
    test_wrong_key_retrigger();
    test_watchdog();
    test_simultaneous();
    test_saturation();
    test_reset_mid_pulse();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
